// File: rtl/gal_olmc_bank.sv
// Bank of N GAL output logic macrocells: per-channel registered/combinational build, output inversion, OE passthrough, feedback.
// Optional test-mode register preload (ports PL, PL_D) is enabled by defining GAL_OLMC_PRELOAD_EN.
module gal_olmc_bank #(
  parameter int          N          = 8,
  parameter logic [31:0] REGISTERED = '0,
  parameter logic [31:0] INVERTED   = '0
) (
  input  logic         C,
  input  logic         AR_N,
  input  logic [N-1:0] A,
  input  logic         SP,
`ifdef GAL_OLMC_PRELOAD_EN
  input  logic         PL,
  input  logic [N-1:0] PL_D,
`endif
  input  logic [N-1:0] OE,
  output logic [N-1:0] Y,
  output logic [N-1:0] Y_EN,
  output logic [N-1:0] FB
);

  // Masks are taken from the low N bits; narrower overrides arrive zero-extended.
  localparam logic [N-1:0] REG_MASK = REGISTERED[N-1:0];
  localparam logic [N-1:0] INV_MASK = INVERTED[N-1:0];

  assign Y_EN = OE;

  // Clock/reset/preset only have loads when at least one channel is registered.
  logic unused_ctrl;
`ifdef GAL_OLMC_PRELOAD_EN
  assign unused_ctrl = ^{C, AR_N, SP, PL, PL_D};
`else
  assign unused_ctrl = ^{C, AR_N, SP};
`endif

  for (genvar i = 0; i < N; i++) begin : g_ch
    if (REG_MASK[i]) begin : g_reg
      logic q_d;
      logic q_q;

      // Clocked priority: preload, then synchronous preset, then array term.
      always_comb begin
        q_d = A[i];
        if (SP) q_d = 1'b1;
`ifdef GAL_OLMC_PRELOAD_EN
        if (PL) q_d = PL_D[i];
`endif
      end

      always_ff @(posedge C or negedge AR_N) begin
        if (!AR_N) q_q <= 1'b0;
        else       q_q <= q_d;
      end

      assign Y[i]  = q_q ^ INV_MASK[i];
      assign FB[i] = q_q;
    end else begin : g_comb
      assign Y[i]  = A[i] ^ INV_MASK[i];
      assign FB[i] = Y[i];
    end
  end

endmodule

// File: tb/tb_gal_olmc_bank.sv
// Directed bench for gal_olmc_bank with N=4, REGISTERED=4'b0011, INVERTED=4'b0101.
module tb_gal_olmc_bank;

  logic       C;
  logic       AR_N;
  logic [3:0] A;
  logic       SP;
  logic [3:0] OE;
  logic [3:0] Y;
  logic [3:0] Y_EN;
  logic [3:0] FB;
`ifdef GAL_OLMC_PRELOAD_EN
  logic       PL;
  logic [3:0] PL_D;
`endif

  int checks   = 0;
  int failures = 0;

  gal_olmc_bank #(
    .N          (4),
    .REGISTERED (4'b0011),
    .INVERTED   (4'b0101)
  ) dut (
    .C    (C),
    .AR_N (AR_N),
    .A    (A),
    .SP   (SP),
`ifdef GAL_OLMC_PRELOAD_EN
    .PL   (PL),
    .PL_D (PL_D),
`endif
    .OE   (OE),
    .Y    (Y),
    .Y_EN (Y_EN),
    .FB   (FB)
  );

  initial C = 1'b0;
  always #5 C = ~C;

  initial begin
    #20000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [3:0] observed, input logic [3:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s: observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  initial begin
    AR_N = 1'b0;
    A    = 4'b1111;
    SP   = 1'b0;
    OE   = 4'b1111;
`ifdef GAL_OLMC_PRELOAD_EN
    PL   = 1'b0;
    PL_D = 4'b0000;
`endif

    // Test 1: in reset, registered channels show INVERTED, comb channels follow A.
    #2;
    check("rst_y",    Y,    4'b1001);
    check("rst_fb",   FB,   4'b1000);
    check("rst_y_en", Y_EN, 4'b1111);

    // Test 2: release, registered half waits for the first edge.
    @(negedge C);
    AR_N = 1'b1;
    A    = 4'b1010;
    #1;
    check("rel_y_pre",  Y,  4'b1101);
    check("rel_fb_pre", FB, 4'b1100);
    @(posedge C); #1;
    check("rel_y_post",  Y,  4'b1111);
    check("rel_fb_post", FB, 4'b1110);

    // Test 3: synchronous preset overrides A.
    @(negedge C);
    SP = 1'b1;
    A  = 4'b0000;
    #1;
    check("sp_y_pre", Y, 4'b0111);
    @(posedge C); #1;
    check("sp_y",  Y,  4'b0110);
    check("sp_fb", FB, 4'b0111);

    // Test 4: async reset mid-cycle, then held through an edge with SP=1.
    @(negedge C);
    SP = 1'b0;
    #2;
    AR_N = 1'b0;
    #1;
    check("ar_mid_fb", FB, 4'b0100);
    check("ar_mid_y",  Y,  4'b0101);
    SP = 1'b1;
    @(posedge C); #1;
    check("ar_edge_fb", FB, 4'b0100);
    check("ar_edge_y",  Y,  4'b0101);

    // Test 5: preload (when built in) beats SP; otherwise SP sets both bits.
    @(negedge C);
    AR_N = 1'b1;
`ifdef GAL_OLMC_PRELOAD_EN
    PL   = 1'b1;
    PL_D = 4'b0010;
    @(posedge C); #1;
    check("pl_fb", FB, 4'b0110);
    check("pl_y",  Y,  4'b0111);
    @(negedge C);
    PL = 1'b0;
`else
    @(posedge C); #1;
    check("sp2_fb", FB, 4'b0111);
    check("sp2_y",  Y,  4'b0110);
    @(negedge C);
`endif

    // Plain capture of A with no preset.
    SP = 1'b0;
    A  = 4'b0001;
    @(posedge C); #1;
    check("cap_y",  Y,  4'b0100);
    check("cap_fb", FB, 4'b0101);

    // Test 6: OE low gates only Y_EN; registers keep clocking.
    @(negedge C);
    OE = 4'b0000;
    A  = 4'b0110;
    #1;
    check("oe_off_en", Y_EN, 4'b0000);
    @(posedge C); #1;
    check("oe_t1_y",  Y,  4'b0011);
    check("oe_t1_fb", FB, 4'b0010);
    @(negedge C);
    A = 4'b1001;
    #1;
    check("oe_lat_y", Y, 4'b1111);
    @(posedge C); #1;
    check("oe_t2_y",  Y,    4'b1100);
    check("oe_t2_fb", FB,   4'b1101);
    check("oe_t2_en", Y_EN, 4'b0000);
    @(negedge C);
    A = 4'b0110;
    @(posedge C); #1;
    check("oe_t3_y",  Y,  4'b0011);
    check("oe_t3_fb", FB, 4'b0010);

    // Mixed OE pattern passes straight through.
    OE = 4'b1010;
    #1;
    check("oe_mix_en", Y_EN, 4'b1010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
